spi_slave_param: RTL and testbench
==================================

Name: spi_slave_param

Overview:
- SPI slave with a parameterised word width, supporting all four CPOL/CPHA modes and back-to-back multi-word frames within a single chip-select assertion.
- Oversamples SCLK, CS_N and MOSI in the system clk domain.
- Exchanges words with the host logic through a valid/ready TX holding register and a one-cycle RX strobe.
- Sits between the board-level SPI pins (tri-state handled at top level) and the register/command layer.

Parameters:
DATA_W, 8, bits per SPI word (range 4..32)
SYNC_STAGES, 2, synchroniser flops on sclk/cs_n/mosi (min 2)

Ports:
clk  in  1  system clock; must be at least 4x sclk
reset  in  1  asynchronous, active-high
cpol  in  1  clock polarity; latched on cs_n fall
cpha  in  1  clock phase; latched on cs_n fall
sclk  in  1  SPI clock from master
cs_n  in  1  chip select, active-low
mosi  in  1  master-out data
miso  out  1  slave-out data; 0 when not selected
miso_oe  out  1  output enable for the top-level tri-state buffer
tx_data  in  DATA_W  next word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  TX holding register empty
rx_data  out  DATA_W  last complete received word
rx_valid  out  1  one-clk strobe: rx_data updated
tx_underrun  out  1  one-clk strobe: word started with no valid TX data
busy  out  1  high while in ACTIVE

Behaviour:
- Reset values: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, busy=0, state=IDLE, bit_cnt=0, holding register empty.
- Synchronisation: sclk, cs_n and mosi each pass through SYNC_STAGES flops (synchroniser reset value of sclk = cpol, cs_n = 1). Edges are detected by comparing the last two synchronised samples.
- Edge roles: a leading edge is idle to active SCLK level; a trailing edge is the reverse.
  - CPHA=0: sample on leading edge, shift on trailing edge.
  - CPHA=1: shift on leading edge, sample on trailing edge.
- FSM IDLE -> ACTIVE on cs_n falling edge: latch cpol/cpha, clear bit_cnt, set miso_oe=1, busy=1.
- FSM ACTIVE -> IDLE on cs_n rising edge: miso_oe=0, miso=0. A partial word is discarded (no rx_valid) and bit_cnt is cleared.
- Edges seen in IDLE are ignored. cpol/cpha changes during ACTIVE are ignored.
- RX:
  - Each sample edge shifts mosi into the RX shift register and increments bit_cnt.
  - When bit_cnt reaches DATA_W: load rx_data and pulse rx_valid on the following clk, then wrap bit_cnt to 0. The frame continues with the next word.
  - rx_data holds its value until the next complete word. No backpressure: the host must consume within one word time.
- TX load point is the start of each word:
  - CPHA=0: the cs_n fall for the first word, and the trailing edge that completes a word for later words.
  - CPHA=1: the leading edge when bit_cnt==0.
- At the load point:
  - If the holding register is full: shift register <= holding, first bit driven on miso, holding emptied, tx_ready=1 on the next clk.
  - If the holding register is empty: shift register <= 0 and tx_underrun pulses for one clk.
- Subsequent shift edges drive the next bit onto miso. Bit order is MSB first by default.
- Holding register write: tx_valid && tx_ready captures tx_data; tx_ready falls on the next clk.
- If a load and a write coincide, the load takes the old holding content, the new data is captured, and tx_ready stays 0.
- Simultaneous cs_n rise and sample edge: cs_n rise wins; the sample is dropped.
- Latency: rx_valid appears SYNC_STAGES+2 clk after the physical final sample edge.

Optional Feature:
- Macro: SPI_SLAVE_LSB_FIRST_EN.
- Defined: adds input port lsb_first, latched on cs_n fall. When lsb_first=1, TX shifts out bit 0 first and RX assembles so that the first received bit lands in bit 0.
- Undefined: no lsb_first port; MSB first always.

Decomposition:
- Package spi_pkg:
  - FSM state encoding (IDLE, ACTIVE).
  - Mode constants MODE0..MODE3 as {cpol,cpha}.
  - Function computing bit_cnt width as $clog2(DATA_W+1).
- Sub-module spi_sync_edge:
  - Parameterised SYNC_STAGES synchroniser with rise/fall strobes.
  - Instantiated for sclk and cs_n. mosi uses synchroniser-only mode.

Test Plan:
- Mode 0, DATA_W=8: preload tx_data=0xA5, master sends 0x3C -> miso shows 1,0,1,0,0,1,0,1; rx_valid once; rx_data=0x3C.
- Modes 1, 2, 3 each exchanging 0x96/0x69 -> correct bits in both directions for every mode; rx_valid exactly once per word.
- Three words in one cs_n low, host reloads only twice -> miso carries word1, word2, then 0x00; tx_underrun pulses at the third word start; three rx_valid.
- cs_n rises after 5 bits -> no rx_valid, busy=0, miso_oe=0. The next frame receives 0x81 correctly.
- reset asserted mid-word -> all outputs at reset values immediately. A post-reset frame in mode 3 exchanges 0xFF/0x00 correctly.
- DATA_W=16 with SPI_SLAVE_LSB_FIRST_EN defined and lsb_first=1: tx 0x1234 -> miso bit order 0,0,1,0,1,1,0,0,...; rx 0xBEEF reassembled exactly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the spi_slave_param slice: FSM states, SPI mode codes
// and the bit-counter width helper.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

  // Mode codes as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int unsigned bit_cnt_width(input int unsigned data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// SYNC_STAGES-deep synchroniser for one SPI pin; optionally produces rise/fall strobes
// from the last two synchronised samples (EDGE_EN=0 gives synchroniser-only mode).
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          EDGE_EN     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic rst_val,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= {SYNC_STAGES{rst_val}};
    else       sync <= {sync[SYNC_STAGES-2:0], d};
  end

  assign q = sync[SYNC_STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic q_d;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) q_d <= rst_val;
        else       q_d <= q;
      end
      assign rise = q & ~q_d;
      assign fall = ~q & q_d;
    end else begin : g_no_edge
      assign rise = 1'b0;
      assign fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave: all CPOL/CPHA modes, multi-word frames, valid/ready TX holding register.
// Defining SPI_SLAVE_LSB_FIRST_EN adds a lsb_first input (latched on cs_n fall).
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpol,
  input  logic              cpha,
`ifdef SPI_SLAVE_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int unsigned        CNT_W    = bit_cnt_width(DATA_W);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DATA_W);

  spi_state_t        state, state_next;
  logic              sclk_q, sclk_rise, sclk_fall;
  logic              cs_q, cs_rise, cs_fall;
  logic              mosi_q, mosi_rise, mosi_fall;
  logic              sync_unused;
  logic              cpol_q, cpha_q, lsb_q;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_shift, tx_shift, hold;
  logic              hold_full;
  logic              lead, trail, sample_ev, shift_edge, load_ev, shift_ev, wr;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sclk_sync (
    .clk(clk), .reset(reset), .rst_val(cpol), .d(sclk),
    .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_cs_sync (
    .clk(clk), .reset(reset), .rst_val(1'b1), .d(cs_n),
    .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_mosi_sync (
    .clk(clk), .reset(reset), .rst_val(1'b0), .d(mosi),
    .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign sync_unused = ^{sclk_q, cs_q, mosi_rise, mosi_fall};

`ifdef SPI_SLAVE_LSB_FIRST_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      lsb_q <= 1'b0;
    else if (cs_fall && state == IDLE) lsb_q <= lsb_first;
  end
`else
  assign lsb_q = 1'b0;
`endif

  // A word starts at bit_cnt==0 on a shift edge; CPHA=0 first word starts at cs_n fall.
  always_comb begin
    lead       = cpol_q ? sclk_fall : sclk_rise;
    trail      = cpol_q ? sclk_rise : sclk_fall;
    sample_ev  = (state == ACTIVE) && !cs_rise && (cpha_q ? trail : lead);
    shift_edge = (state == ACTIVE) && !cs_rise && (cpha_q ? lead : trail);
    load_ev    = (cs_fall && state == IDLE && !cpha) || (shift_edge && bit_cnt == '0);
    shift_ev   = shift_edge && bit_cnt != '0;
    wr         = tx_valid && !hold_full;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    miso_oe    = 1'b0;
    miso       = 1'b0;
    case (state)
      IDLE: if (cs_fall) state_next = ACTIVE;
      ACTIVE: begin
        busy    = 1'b1;
        miso_oe = 1'b1;
        miso    = lsb_q ? tx_shift[0] : tx_shift[DATA_W-1];
        if (cs_rise) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign tx_ready = ~hold_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_shift    <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      if (cs_fall && state == IDLE) begin
        cpol_q <= cpol;
        cpha_q <= cpha;
      end

      if (bit_cnt == CNT_FULL) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end
      if ((cs_fall && state == IDLE) || (cs_rise && state == ACTIVE) || bit_cnt == CNT_FULL) begin
        bit_cnt <= '0;
      end else if (sample_ev) begin
        bit_cnt  <= bit_cnt + CNT_W'(1);
        rx_shift <= lsb_q ? {mosi_q, rx_shift[DATA_W-1:1]} : {rx_shift[DATA_W-2:0], mosi_q};
      end

      if (load_ev) begin
        if (hold_full) begin
          tx_shift <= hold;
        end else begin
          tx_shift    <= '0;
          tx_underrun <= 1'b1;
        end
      end else if (shift_ev) begin
        tx_shift <= lsb_q ? {1'b0, tx_shift[DATA_W-1:1]} : {tx_shift[DATA_W-2:0], 1'b0};
      end

      if (wr) hold <= tx_data;
      hold_full <= wr || (hold_full && !load_ev);
    end
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: all SPI modes, multi-word frames, abort, reset;
// the 16-bit LSB-first case runs only when SPI_SLAVE_LSB_FIRST_EN is defined.
module tb_spi_slave_param;
  import spi_pkg::*;

  localparam int unsigned HALF = 80;

  logic        clk = 1'b0, reset = 1'b1;
  logic        cpol = 1'b0, cpha = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy;
  logic [7:0]  rx_data;
  logic        cur_miso, cur_busy, cur_oe;

  int unsigned errors = 0, checks = 0;
  int unsigned rx_cnt = 0, urun_cnt = 0;
  logic [7:0]  rx_log [0:15];
  logic [31:0] mosi_words [0:3];
  logic [31:0] miso_words [0:3];

  always #5 clk = ~clk;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  logic        lsb_first = 1'b0, lsb2 = 1'b1, cs_n2 = 1'b1, tx_valid2 = 1'b0, use2 = 1'b0;
  logic [15:0] tx_data2 = '0;
  logic [15:0] rx_data2;
  logic        miso2, miso_oe2, tx_ready2, rx_valid2, tx_underrun2, busy2;
  int unsigned rx2_cnt = 0;

  spi_slave_param #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .tx_underrun(tx_underrun), .busy(busy)
  );

  spi_slave_param #(.DATA_W(16), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha), .lsb_first(lsb2),
    .sclk(sclk), .cs_n(cs_n2), .mosi(mosi), .miso(miso2), .miso_oe(miso_oe2),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2), .rx_data(rx_data2),
    .rx_valid(rx_valid2), .tx_underrun(tx_underrun2), .busy(busy2)
  );

  assign cur_miso = use2 ? miso2 : miso;
  assign cur_busy = use2 ? busy2 : busy;
  assign cur_oe   = use2 ? miso_oe2 : miso_oe;

  always @(posedge clk) if (rx_valid2) rx2_cnt <= rx2_cnt + 1;
`else
  spi_slave_param #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .tx_underrun(tx_underrun), .busy(busy)
  );

  assign cur_miso = miso;
  assign cur_busy = busy;
  assign cur_oe   = miso_oe;
`endif

  always @(posedge clk) begin
    if (rx_valid) begin
      rx_log[rx_cnt[3:0]] <= rx_data;
      rx_cnt <= rx_cnt + 1;
    end
    if (tx_underrun) urun_cnt <= urun_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_cs(input logic v);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    if (use2) cs_n2 = v;
    else      cs_n  = v;
`else
    cs_n = v;
`endif
  endtask

  task automatic host_write(input logic [7:0] d);
    int unsigned n = 0;
    @(posedge clk); #1;
    while (!tx_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("host_ready", {31'd0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  // Bit-banged master; captures miso at the master's sample edge of each bit.
  task automatic run_frame(input logic [1:0] mode, input int unsigned nwords,
                           input int unsigned nbits, input int unsigned width,
                           input bit lsb, input bit keep_cs);
    logic p_cpol, p_cpha;
    int unsigned idx;
    p_cpol = mode[1];
    p_cpha = mode[0];
    @(posedge clk); #1;
    cpol = p_cpol;
    cpha = p_cpha;
    sclk = p_cpol;
    repeat (4) @(posedge clk);
    #1 set_cs(1'b0);
    #(HALF);
    check("frame_busy", {31'd0, cur_busy}, 32'd1);
    check("frame_oe", {31'd0, cur_oe}, 32'd1);
    for (int unsigned w = 0; w < nwords; w++) begin
      miso_words[w] = '0;
      for (int unsigned b = 0; b < nbits; b++) begin
        idx = lsb ? b : width - 1 - b;
        if (!p_cpha) begin
          mosi = mosi_words[w][idx];
          #(HALF) sclk = ~p_cpol;
          miso_words[w][idx] = cur_miso;
          #(HALF) sclk = p_cpol;
        end else begin
          sclk = ~p_cpol;
          mosi = mosi_words[w][idx];
          #(HALF) sclk = p_cpol;
          miso_words[w][idx] = cur_miso;
          #(HALF);
        end
      end
    end
    if (!keep_cs) begin
      #(HALF) set_cs(1'b1);
      repeat (6) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int unsigned base, ubase;
    logic [1:0] m;
    logic [3:0] li;

    repeat (3) @(posedge clk);
    #1;
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_underrun", {31'd0, tx_underrun}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    // Mode 0 basic exchange
    mosi_words[0] = 32'h3C;
    host_write(8'hA5);
    check("m0_ready_full", {31'd0, tx_ready}, 32'd0);
    base = rx_cnt;
    run_frame(MODE0, 1, 8, 8, 1'b0, 1'b0);
    check("m0_miso", miso_words[0], 32'hA5);
    check("m0_rx_cnt", rx_cnt - base, 32'd1);
    check("m0_rx_data", {24'd0, rx_data}, 32'h3C);
    check("m0_ready_empty", {31'd0, tx_ready}, 32'd1);
    check("m0_busy_end", {31'd0, busy}, 32'd0);
    check("m0_oe_end", {31'd0, miso_oe}, 32'd0);

    // Modes 1..3
    for (int unsigned k = 1; k < 4; k++) begin
      m = 2'(k);
      mosi_words[0] = 32'h96;
      host_write(8'h69);
      base = rx_cnt;
      run_frame(m, 1, 8, 8, 1'b0, 1'b0);
      check($sformatf("m%0d_miso", k), miso_words[0], 32'h69);
      check($sformatf("m%0d_rx_cnt", k), rx_cnt - base, 32'd1);
      check($sformatf("m%0d_rx_data", k), {24'd0, rx_data}, 32'h96);
    end

    // Three words in one frame, only two host writes
    mosi_words[0] = 32'h11;
    mosi_words[1] = 32'h22;
    mosi_words[2] = 32'h33;
    host_write(8'hC3);
    base  = rx_cnt;
    ubase = urun_cnt;
    fork
      run_frame(MODE1, 3, 8, 8, 1'b0, 1'b0);
      host_write(8'h5A);
    join
    check("mw_miso0", miso_words[0], 32'hC3);
    check("mw_miso1", miso_words[1], 32'h5A);
    check("mw_miso2", miso_words[2], 32'h00);
    check("mw_rx_cnt", rx_cnt - base, 32'd3);
    li = 4'(base);
    check("mw_rx0", {24'd0, rx_log[li]}, 32'h11);
    li = 4'(base + 1);
    check("mw_rx1", {24'd0, rx_log[li]}, 32'h22);
    li = 4'(base + 2);
    check("mw_rx2", {24'd0, rx_log[li]}, 32'h33);
    check("mw_underrun", urun_cnt - ubase, 32'd1);

    // Abort after 5 bits, then a clean frame
    mosi_words[0] = 32'hFF;
    base = rx_cnt;
    run_frame(MODE0, 1, 5, 8, 1'b0, 1'b0);
    check("ab_rx_cnt", rx_cnt - base, 32'd0);
    check("ab_busy", {31'd0, busy}, 32'd0);
    check("ab_oe", {31'd0, miso_oe}, 32'd0);
    check("ab_miso", {31'd0, miso}, 32'd0);
    mosi_words[0] = 32'h81;
    host_write(8'h5A);
    base = rx_cnt;
    run_frame(MODE0, 1, 8, 8, 1'b0, 1'b0);
    check("ab2_rx_cnt", rx_cnt - base, 32'd1);
    check("ab2_rx_data", {24'd0, rx_data}, 32'h81);
    check("ab2_miso", miso_words[0], 32'h5A);

    // Reset mid-word, then a mode 3 frame
    mosi_words[0] = 32'hAA;
    host_write(8'h77);
    fork
      run_frame(MODE3, 1, 4, 8, 1'b0, 1'b1);
      host_write(8'h12);
    join
    #3 reset = 1'b1;
    #1;
    check("mr_miso", {31'd0, miso}, 32'd0);
    check("mr_miso_oe", {31'd0, miso_oe}, 32'd0);
    check("mr_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("mr_rx_data", {24'd0, rx_data}, 32'd0);
    check("mr_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("mr_underrun", {31'd0, tx_underrun}, 32'd0);
    check("mr_busy", {31'd0, busy}, 32'd0);
    cs_n = 1'b1;
    sclk = 1'b1;
    cpol = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    mosi_words[0] = 32'hFF;
    host_write(8'h00);
    base  = rx_cnt;
    ubase = urun_cnt;
    run_frame(MODE3, 1, 8, 8, 1'b0, 1'b0);
    check("pr_rx_cnt", rx_cnt - base, 32'd1);
    check("pr_rx_data", {24'd0, rx_data}, 32'hFF);
    check("pr_miso", miso_words[0], 32'h00);
    check("pr_underrun", urun_cnt - ubase, 32'd0);

`ifdef SPI_SLAVE_LSB_FIRST_EN
    // 16-bit LSB-first instance
    @(posedge clk); #1;
    check("l16_ready", {31'd0, tx_ready2}, 32'd1);
    tx_data2  = 16'h1234;
    tx_valid2 = 1'b1;
    @(posedge clk); #1;
    tx_valid2 = 1'b0;
    use2 = 1'b1;
    mosi_words[0] = 32'hBEEF;
    base = rx2_cnt;
    run_frame(MODE0, 1, 16, 16, 1'b1, 1'b0);
    use2 = 1'b0;
    check("l16_miso", miso_words[0], 32'h1234);
    check("l16_rx_cnt", rx2_cnt - base, 32'd1);
    check("l16_rx_data", {16'd0, rx_data2}, 32'hBEEF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
